// File: rtl/bcd_run_ctrl.sv
// Run controller for a cascade of up/down BCD digits with tick prescaler and terminal detect.
// Optional feature: define AUTO_RELOAD_EN to reload the count on terminal match instead of stopping.
module bcd_run_ctrl #(
    parameter int DIGITS   = 2,
    parameter int PRESCALE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  stop,
    input  logic                  load,
    input  logic                  dir,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic [4*DIGITS-1:0]   limit,
    output logic [4*DIGITS-1:0]   count,
    output logic [1:0]            state,
    output logic                  busy,
    output logic                  done
);

    localparam int W  = 4 * DIGITS;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;
    localparam logic [1:0] S_DONE  = 2'b11;

    logic [W-1:0]  count_q, count_d;
    logic [1:0]    state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          done_q, done_d;
`ifdef AUTO_RELOAD_EN
    logic [W-1:0]  reload_q, reload_d;
`endif

    logic [W-1:0]  load_clamped;
    logic [W-1:0]  stepped;
    logic          tick;

    assign tick = (state_q == S_RUN) && (pre_q == PRE_LAST);

    always_comb begin : clamp_b
        logic [3:0] nib;
        load_clamped = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            nib = load_val[4*i +: 4];
            load_clamped[4*i +: 4] = (nib > 4'd9) ? 4'd9 : nib;
        end
    end

    // Ripple carry/borrow through the digits; a saturated cascade wraps naturally.
    always_comb begin : step_b
        logic       carry;
        logic [3:0] dig;
        carry   = 1'b1;
        stepped = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            dig = count_q[4*i +: 4];
            if (!carry) begin
                stepped[4*i +: 4] = dig;
            end else if (!dir) begin
                if (dig >= 4'd9) begin
                    stepped[4*i +: 4] = 4'd0;
                end else begin
                    stepped[4*i +: 4] = dig + 4'd1;
                    carry = 1'b0;
                end
            end else begin
                if (dig == 4'd0) begin
                    stepped[4*i +: 4] = 4'd9;
                end else begin
                    stepped[4*i +: 4] = dig - 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    always_comb begin : next_b
        count_d = count_q;
        state_d = state_q;
        pre_d   = pre_q;
        done_d  = 1'b0;
`ifdef AUTO_RELOAD_EN
        reload_d = reload_q;
`endif
        if (stop) begin
            state_d = S_IDLE;
            pre_d   = '0;
        end else if (load && (state_q != S_RUN)) begin
            count_d = load_clamped;
`ifdef AUTO_RELOAD_EN
            reload_d = load_clamped;
`endif
            state_d = S_IDLE;
            pre_d   = '0;
        end else if (pause && (state_q == S_RUN)) begin
            state_d = S_PAUSE;
        end else if (start && ((state_q == S_IDLE) || (state_q == S_DONE))) begin
            if (count_q == limit) begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end else begin
                state_d = S_RUN;
                pre_d   = '0;
            end
        end else if (start && (state_q == S_PAUSE)) begin
            state_d = S_RUN;
        end else if (state_q == S_RUN) begin
            if (tick) begin
                pre_d = '0;
                // count_q is always valid BCD, so a limit with a digit >9 never matches.
                if (stepped == limit) begin
                    done_d = 1'b1;
`ifdef AUTO_RELOAD_EN
                    count_d = reload_q;
`else
                    count_d = stepped;
                    state_d = S_DONE;
`endif
                end else begin
                    count_d = stepped;
                end
            end else begin
                pre_d = pre_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            state_q <= S_IDLE;
            pre_q   <= '0;
            done_q  <= 1'b0;
`ifdef AUTO_RELOAD_EN
            reload_q <= '0;
`endif
        end else begin
            count_q <= count_d;
            state_q <= state_d;
            pre_q   <= pre_d;
            done_q  <= done_d;
`ifdef AUTO_RELOAD_EN
            reload_q <= reload_d;
`endif
        end
    end

    assign count = count_q;
    assign state = state_q;
    assign done  = done_q;
    assign busy  = (state_q == S_RUN) || (state_q == S_PAUSE);

endmodule

// File: tb/tb_bcd_run_ctrl.sv
// Self-checking bench for bcd_run_ctrl: directed scenarios plus randomized commands vs an integer model.
module tb_bcd_run_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, pause, stop, load, dir;
    logic [7:0] load_val, limit;
    logic [7:0] c1, c4;
    logic [1:0] s1, s4;
    logic       b1, b4, d1, d4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bcd_run_ctrl #(.DIGITS(2), .PRESCALE(1)) u1 (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .stop(stop), .load(load),
        .dir(dir), .load_val(load_val), .limit(limit),
        .count(c1), .state(s1), .busy(b1), .done(d1)
    );

    bcd_run_ctrl #(.DIGITS(2), .PRESCALE(4)) u4 (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .stop(stop), .load(load),
        .dir(dir), .load_val(load_val), .limit(limit),
        .count(c4), .state(s4), .busy(b4), .done(d4)
    );

    // Reference model: count held as an integer 0..99, state as 0..3.
    function automatic int bcd_val(input logic [7:0] v);
        if (v[7:4] > 4'd9 || v[3:0] > 4'd9) return -1;
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic int clamp_val(input logic [7:0] v);
        int hi, lo;
        hi = (v[7:4] > 4'd9) ? 9 : int'(v[7:4]);
        lo = (v[3:0] > 4'd9) ? 9 : int'(v[3:0]);
        return hi * 10 + lo;
    endfunction

    function automatic logic [7:0] to_bcd(input int n);
        logic [3:0] hi, lo;
        hi = 4'(n / 10);
        lo = 4'(n % 10);
        return {hi, lo};
    endfunction

    function automatic void model_step(input int p, inout int cnt, inout int rel,
                                       inout int st, inout int pre, output bit dn);
        int lim, nxt;
        bit tk;
        lim = bcd_val(limit);
        dn  = 0;
        tk  = (st == 1) && (pre == p - 1);
        if (stop) begin
            st = 0; pre = 0;
        end else if (load && st != 1) begin
            cnt = clamp_val(load_val); rel = cnt; st = 0; pre = 0;
        end else if (pause && st == 1) begin
            st = 2;
        end else if (start && (st == 0 || st == 3)) begin
            if (cnt == lim) begin st = 3; dn = 1; end
            else begin st = 1; pre = 0; end
        end else if (start && st == 2) begin
            st = 1;
        end else if (st == 1) begin
            if (tk) begin
                pre = 0;
                nxt = dir ? (cnt + 99) % 100 : (cnt + 1) % 100;
                if (nxt == lim) begin
                    dn = 1;
`ifdef AUTO_RELOAD_EN
                    cnt = rel;
`else
                    cnt = nxt; st = 3;
`endif
                end else begin
                    cnt = nxt;
                end
            end else begin
                pre = pre + 1;
            end
        end
    endfunction

    int m1_cnt, m1_rel, m1_st, m1_pre; bit m1_dn;
    int m4_cnt, m4_rel, m4_st, m4_pre; bit m4_dn;

    always @(posedge clk or posedge rst) begin
        int c, r, s, p;
        bit dn;
        if (rst) begin
            m1_cnt <= 0; m1_rel <= 0; m1_st <= 0; m1_pre <= 0; m1_dn <= 0;
            m4_cnt <= 0; m4_rel <= 0; m4_st <= 0; m4_pre <= 0; m4_dn <= 0;
        end else begin
            c = m1_cnt; r = m1_rel; s = m1_st; p = m1_pre;
            model_step(1, c, r, s, p, dn);
            m1_cnt <= c; m1_rel <= r; m1_st <= s; m1_pre <= p; m1_dn <= dn;
            c = m4_cnt; r = m4_rel; s = m4_st; p = m4_pre;
            model_step(4, c, r, s, p, dn);
            m4_cnt <= c; m4_rel <= r; m4_st <= s; m4_pre <= p; m4_dn <= dn;
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_load(input logic [7:0] v);
        stop = 1; cyc(); stop = 0;
        load = 1; load_val = v; cyc(); load = 0;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (c1 !== 8'h00) begin n_err++; $display("FAIL reset_count got %h exp 00", c1); end
        n_cmp++; if (s1 !== 2'b00) begin n_err++; $display("FAIL reset_state got %b exp 00", s1); end
        n_cmp++; if (d1 !== 1'b0 || b1 !== 1'b0) begin n_err++; $display("FAIL reset_done_busy got %b%b exp 00", d1, b1); end
        cyc(); rst = 0; cyc();
        n_cmp++; if (s4 !== 2'b00 || c4 !== 8'h00) begin n_err++; $display("FAIL reset_idle got %b/%h exp 00/00", s4, c4); end
    endtask

    task automatic test_count_up();
        logic [7:0] ec;
        do_load(8'h05); limit = 8'h08; dir = 0; start = 1; cyc(); start = 0;
        n_cmp++; if (s1 !== 2'b01 || c1 !== 8'h05 || b1 !== 1'b1) begin n_err++; $display("FAIL up_enter_run got %b/%h/%b exp 01/05/1", s1, c1, b1); end
        for (int i = 0; i < 3; i++) begin
            cyc();
            ec = 8'h06 + 8'(i);
            n_cmp++; if (c1 !== ec) begin n_err++; $display("FAIL up_count got %h exp %h", c1, ec); end
            n_cmp++; if (d1 !== (i == 2)) begin n_err++; $display("FAIL up_done got %b exp %b", d1, (i == 2)); end
        end
        n_cmp++; if (s1 !== 2'b11 || b1 !== 1'b0) begin n_err++; $display("FAIL up_state_done got %b/%b exp 11/0", s1, b1); end
        cyc();
        n_cmp++; if (d1 !== 1'b0 || c1 !== 8'h08 || s1 !== 2'b11) begin n_err++; $display("FAIL up_hold got %b/%h/%b exp 0/08/11", d1, c1, s1); end
    endtask

    task automatic test_count_down();
        logic [7:0] seq [3];
        seq = '{8'h99, 8'h98, 8'h97};
        do_load(8'h00); limit = 8'h97; dir = 1; start = 1; cyc(); start = 0;
        n_cmp++; if (s1 !== 2'b01 || c1 !== 8'h00) begin n_err++; $display("FAIL dn_enter_run got %b/%h exp 01/00", s1, c1); end
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_cmp++; if (c1 !== seq[i]) begin n_err++; $display("FAIL dn_count got %h exp %h", c1, seq[i]); end
            n_cmp++; if (d1 !== (i == 2)) begin n_err++; $display("FAIL dn_done got %b exp %b", d1, (i == 2)); end
        end
        cyc();
        n_cmp++; if (d1 !== 1'b0 || s1 !== 2'b11) begin n_err++; $display("FAIL dn_single_pulse got %b/%b exp 0/11", d1, s1); end
    endtask

    task automatic test_pause_resume();
        do_load(8'h10); limit = 8'h12; dir = 0; start = 1; cyc(); start = 0;
        cyc(); cyc();
        pause = 1; cyc(); pause = 0;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (s4 !== 2'b10 || c4 !== 8'h10 || b4 !== 1'b1) begin n_err++; $display("FAIL ps_hold got %b/%h/%b exp 10/10/1", s4, c4, b4); end
            cyc();
        end
        start = 1; cyc(); start = 0;
        n_cmp++; if (s4 !== 2'b01 || c4 !== 8'h10) begin n_err++; $display("FAIL ps_resume got %b/%h exp 01/10", s4, c4); end
        cyc();
        n_cmp++; if (c4 !== 8'h10) begin n_err++; $display("FAIL ps_resume1 got %h exp 10", c4); end
        cyc();
        n_cmp++; if (c4 !== 8'h11) begin n_err++; $display("FAIL ps_step11 got %h exp 11", c4); end
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_cmp++; if (c4 !== 8'h11 || d4 !== 1'b0) begin n_err++; $display("FAIL ps_wait got %h/%b exp 11/0", c4, d4); end
        end
        cyc();
        n_cmp++; if (c4 !== 8'h12 || d4 !== 1'b1 || s4 !== 2'b11) begin n_err++; $display("FAIL ps_term got %h/%b/%b exp 12/1/11", c4, d4, s4); end
    endtask

    task automatic test_clamp_start_match();
        do_load(8'hA3);
        n_cmp++; if (c1 !== 8'h93 || s1 !== 2'b00) begin n_err++; $display("FAIL clamp got %h/%b exp 93/00", c1, s1); end
        limit = 8'h93; start = 1; cyc(); start = 0;
        n_cmp++; if (s1 !== 2'b11 || d1 !== 1'b1 || c1 !== 8'h93) begin n_err++; $display("FAIL match_start got %b/%b/%h exp 11/1/93", s1, d1, c1); end
        cyc();
        n_cmp++; if (s1 !== 2'b11 || d1 !== 1'b0 || c1 !== 8'h93) begin n_err++; $display("FAIL match_hold got %b/%b/%h exp 11/0/93", s1, d1, c1); end
    endtask

    task automatic test_async_reset();
        do_load(8'h00); limit = 8'h50; dir = 0; start = 1; cyc(); start = 0;
        cyc(); cyc();
        #2 rst = 1; #1;
        n_cmp++; if (c1 !== 8'h00 || s1 !== 2'b00 || d1 !== 1'b0) begin n_err++; $display("FAIL arst got %h/%b/%b exp 00/00/0", c1, s1, d1); end
        cyc(); rst = 0; cyc();
        n_cmp++; if (s1 !== 2'b00 || c1 !== 8'h00 || b1 !== 1'b0) begin n_err++; $display("FAIL arst_idle got %b/%h/%b exp 00/00/0", s1, c1, b1); end
    endtask

`ifdef AUTO_RELOAD_EN
    task automatic test_auto_reload();
        do_load(8'h10); limit = 8'h12; dir = 0; start = 1; cyc(); start = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_cmp++; if (c1 !== ((i % 2 == 0) ? 8'h11 : 8'h10) || d1 !== (i % 2 == 1) || s1 !== 2'b01) begin
                n_err++; $display("FAIL autoreload got %h/%b/%b step %0d", c1, d1, s1, i);
            end
        end
        stop = 1; cyc(); stop = 0;
        n_cmp++; if (s1 !== 2'b00) begin n_err++; $display("FAIL autoreload_stop got %b exp 00", s1); end
    endtask
`endif

    task automatic test_random();
        int r;
        for (int k = 0; k < 1500; k++) begin
            n_cmp++; if (c1 !== to_bcd(m1_cnt) || s1 !== 2'(m1_st) || d1 !== m1_dn || b1 !== (m1_st == 1 || m1_st == 2)) begin
                n_err++; $display("FAIL rand_p1 k=%0d got %h/%b/%b/%b exp %h/%0d/%b", k, c1, s1, d1, b1, to_bcd(m1_cnt), m1_st, m1_dn);
            end
            n_cmp++; if (c4 !== to_bcd(m4_cnt) || s4 !== 2'(m4_st) || d4 !== m4_dn || b4 !== (m4_st == 1 || m4_st == 2)) begin
                n_err++; $display("FAIL rand_p4 k=%0d got %h/%b/%b/%b exp %h/%0d/%b", k, c4, s4, d4, b4, to_bcd(m4_cnt), m4_st, m4_dn);
            end
            stop  = ($urandom_range(0, 99) < 3);
            load  = ($urandom_range(0, 99) < 8);
            pause = !load && ($urandom_range(0, 99) < 8);
            start = ($urandom_range(0, 99) < 15);
            dir   = ($urandom_range(0, 99) < 30);
            load_val = 8'($urandom);
            r = $urandom_range(0, 99);
            if (r < 8) limit = to_bcd($urandom_range(0, 99));
            else if (r < 10) limit = 8'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1; #1 rst = 0;
            end
            cyc();
        end
        stop = 0; load = 0; pause = 0; start = 0;
    endtask

    initial begin
        rst = 1; start = 0; pause = 0; stop = 0; load = 0; dir = 0;
        load_val = 8'h00; limit = 8'h00;
        test_reset();
`ifdef AUTO_RELOAD_EN
        test_auto_reload();
`else
        test_count_up();
        test_count_down();
        test_pause_resume();
`endif
        test_clamp_start_match();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
